// File: rtl/quad_word_serializer.sv
// quad_word_serializer
// Snapshots four upstream register words on a capture strobe and streams them
// out one word per beat over a valid/ready handshake. Captures that arrive
// while a burst is in flight are dropped and counted (saturating), except on
// the last-beat transfer cycle, where they start a back-to-back burst.
//
// Build option: define QWSER_CHECKSUM_EN to append a fifth beat carrying the
// mod-2^WIDTH sum of the four captured words.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no burst in flight, waiting for capture
// SEND  | presenting word_q[idx_q] with out_valid high
module quad_word_serializer #(
   parameter int WIDTH  = 32,
   parameter int DROP_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [WIDTH-1:0]  in_c,
   input  logic [WIDTH-1:0]  in_d,
   input  logic              capture,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [2:0]        out_index,
   output logic              busy,
   output logic [DROP_W-1:0] drop_count
);

`ifdef QWSER_CHECKSUM_EN
   localparam int         NWORDS   = 5;
   localparam logic [2:0] LAST_IDX = 3'd4;
`else
   localparam int         NWORDS   = 4;
   localparam logic [2:0] LAST_IDX = 3'd3;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [DROP_W-1:0]   drop_q, drop_d;
   logic [WIDTH-1:0]    word_q [NWORDS];
   logic [WIDTH-1:0]    word_d [NWORDS];
   logic                load;
   logic                last_xfer;

   // State, beat index, drop counter and word buffer registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         drop_q  <= '0;
         for (int i = 0; i < NWORDS; i++) begin
            word_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
         for (int i = 0; i < NWORDS; i++) begin
            word_q[i] <= word_d[i];
         end
      end
   end

   // Next-state: burst sequencing, capture acceptance and drop counting
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      drop_d    = drop_q;
      word_d    = word_q;
      load      = 1'b0;
      last_xfer = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture) begin
               load    = 1'b1;
               state_d = SEND;
               idx_d   = 3'd0;
            end
         end
         SEND: begin
            last_xfer = out_ready && (idx_q == LAST_IDX);
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = 3'd0;
                  if (capture) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
            // a capture that cannot start a new burst is lost; count it
            if (capture && !last_xfer && (drop_q != {DROP_W{1'b1}})) begin
               drop_d = drop_q + DROP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end
      endcase
      if (load) begin
         word_d[0] = in_a;
         word_d[1] = in_b;
         word_d[2] = in_c;
         word_d[3] = in_d;
`ifdef QWSER_CHECKSUM_EN
         word_d[4] = in_a + in_b + in_c + in_d;
`endif
      end
   end

   // Output decode: data is forced to zero whenever no beat is offered
   always_comb begin
      out_data = '0;
      if (state_q == SEND) begin
         case (idx_q)
            3'd0:    out_data = word_q[0];
            3'd1:    out_data = word_q[1];
            3'd2:    out_data = word_q[2];
            3'd3:    out_data = word_q[3];
`ifdef QWSER_CHECKSUM_EN
            3'd4:    out_data = word_q[4];
`endif
            default: out_data = '0;
         endcase
      end
      out_valid  = (state_q == SEND);
      busy       = (state_q == SEND);
      out_last   = (state_q == SEND) && (idx_q == LAST_IDX);
      out_index  = idx_q;
      drop_count = drop_q;
   end

endmodule
